// File: rtl/teclado_atm.sv
`default_nettype none
// ============================================================================
// Module      : teclado_atm
// Description : Keypad front-end for the ATM transaction controller.
//               Debounces the raw key level from the scanner, accepts exactly
//               one event per physical press and turns it into either a PIN
//               digit strobe or a decimal-to-binary amount accumulation with
//               an ENTER strobe.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-low reset
//               tecla_activa - raw key-pressed level (may bounce)
//               tecla_codigo - key code: 0-9 digit, A ENTER, B CLEAR, C-F none
//               modo_monto   - 0 = PIN entry, 1 = amount entry
//               digito       - accepted PIN digit (valid with digito_stb)
//               digito_stb   - one-cycle pulse per accepted PIN digit
//               monto        - running / final amount, unsigned binary
//               monto_stb    - one-cycle pulse on a valid ENTER in amount mode
//               error_tecla  - one-cycle pulse when an accepted key is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module teclado_atm #(
  parameter int DEBOUNCE_CYCLES = 4,   // 1..255
  parameter int MAX_DIGITS      = 9    // 1..9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tecla_activa,
  input  logic [3:0]  tecla_codigo,
  input  logic        modo_monto,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        error_tecla
);

  localparam logic [1:0] c_ST_IDLE         = 2'd0;
  localparam logic [1:0] c_ST_DEBOUNCE     = 2'd1;
  localparam logic [1:0] c_ST_ACCEPT       = 2'd2;
  localparam logic [1:0] c_ST_WAIT_RELEASE = 2'd3;

  localparam logic [7:0] c_DEB_CYCLES = 8'(DEBOUNCE_CYCLES);
  localparam logic [3:0] c_MAX_DIGITS = 4'(MAX_DIGITS);
  localparam logic [3:0] c_KEY_ENTER  = 4'hA;
  localparam logic [3:0] c_KEY_CLEAR  = 4'hB;

  logic [1:0]  r_state;
  logic [7:0]  r_deb_cnt;
  logic [3:0]  r_code;
  logic [3:0]  r_ndig;
  logic        r_clr_pend;   // clears the accumulator the cycle after monto_stb

  logic        w_is_digit;
  logic [31:0] w_monto_next;

  assign w_is_digit = (r_code <= 4'd9);

  // A digit is only appended while fewer than MAX_DIGITS (<= 9) are held, so
  // the previous value is at most 99,999,999 and monto*10 + 9 stays below
  // 1,000,000,000. The upper nibble of the 36-bit product is therefore always
  // zero and a 32-bit computation is exact.
  assign w_monto_next = (monto * 32'd10) + {28'd0, r_code};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_IDLE;
      r_deb_cnt   <= 8'd0;
      r_code      <= 4'd0;
      r_ndig      <= 4'd0;
      r_clr_pend  <= 1'b0;
      digito      <= 4'd0;
      digito_stb  <= 1'b0;
      monto       <= 32'd0;
      monto_stb   <= 1'b0;
      error_tecla <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction: cleared every cycle and only
      // set on the exit edge of ACCEPT, which lasts exactly one cycle.
      digito_stb  <= 1'b0;
      monto_stb   <= 1'b0;
      error_tecla <= 1'b0;

      if (r_clr_pend) begin
        monto      <= 32'd0;
        r_ndig     <= 4'd0;
        r_clr_pend <= 1'b0;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (tecla_activa) begin
            r_code    <= tecla_codigo;
            r_deb_cnt <= 8'd1;
            r_state   <= c_ST_DEBOUNCE;
          end
        end

        c_ST_DEBOUNCE: begin
          // Any drop-out or code change restarts from IDLE; the new code is
          // latched on the following edge.
          if (!tecla_activa || (tecla_codigo != r_code)) begin
            r_deb_cnt <= 8'd0;
            r_state   <= c_ST_IDLE;
          end else if (r_deb_cnt == c_DEB_CYCLES) begin
            r_state <= c_ST_ACCEPT;
          end else begin
            r_deb_cnt <= r_deb_cnt + 8'd1;
          end
        end

        c_ST_ACCEPT: begin
          r_deb_cnt <= 8'd0;
          r_state   <= c_ST_WAIT_RELEASE;
          if (!modo_monto) begin
            // PIN mode: only digits matter; ENTER/CLEAR/unused are silent.
            if (w_is_digit) begin
              digito     <= r_code;
              digito_stb <= 1'b1;
            end
          end else if (w_is_digit) begin
            if (r_ndig < c_MAX_DIGITS) begin
              monto  <= w_monto_next;
              r_ndig <= r_ndig + 4'd1;
            end else begin
              error_tecla <= 1'b1;
            end
          end else if (r_code == c_KEY_ENTER) begin
            if (r_ndig != 4'd0) begin
              monto_stb  <= 1'b1;
              r_clr_pend <= 1'b1;
            end else begin
              error_tecla <= 1'b1;
            end
          end else if (r_code == c_KEY_CLEAR) begin
            monto  <= 32'd0;
            r_ndig <= 4'd0;
          end
        end

        c_ST_WAIT_RELEASE: begin
          // A held key never repeats: wait for one released cycle.
          if (!tecla_activa) begin
            r_state <= c_ST_IDLE;
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/teclado_atm.md
Name: teclado_atm

Overview:
- Keypad front-end that produces the user-entry strobes consumed by the ATM transaction controller: one `digito`/`digito_stb` pulse per PIN key, and an accumulated `monto` with a `monto_stb` pulse on ENTER.
- Debounces a raw keypad level and emits exactly one event per physical press.
- In amount mode, converts decimal keystrokes to a binary amount.
- Sits between the keypad scanner and the transaction controller.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a key must be stably pressed (same code) before it is accepted; legal range 1..255.
- MAX_DIGITS, 9, maximum decimal digits accepted into `monto`; legal range 1..9.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tecla_activa  input  1  raw key-pressed level from the scanner (may bounce).
- tecla_codigo  input  4  key code: 0x0-0x9 digits, 0xA ENTER, 0xB CLEAR, 0xC-0xF ignored.
- modo_monto  input  1  0 = PIN entry mode, 1 = amount entry mode; sampled at key acceptance.
- digito  output  4  accepted PIN digit value; valid while `digito_stb` = 1.
- digito_stb  output  1  one-cycle pulse per accepted PIN digit.
- monto  output  32  running/final amount, unsigned binary.
- monto_stb  output  1  one-cycle pulse on ENTER in amount mode; `monto` is valid in the same cycle.
- error_tecla  output  1  one-cycle pulse when an accepted key is rejected.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, deb_cnt = 0, ndig = 0, monto = 0, digito = 0, all strobes = 0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: `tecla_activa` = 1 → latch `tecla_codigo` into code_reg, deb_cnt = 1, go to DEBOUNCE.
  - DEBOUNCE: if `tecla_activa` = 0 or `tecla_codigo` != code_reg → IDLE, deb_cnt = 0. Otherwise deb_cnt++. When deb_cnt reaches DEBOUNCE_CYCLES → ACCEPT.
  - ACCEPT (exactly one cycle): perform the key action (below) with outputs registered on exit, then go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until `tecla_activa` = 0 for one full cycle, then IDLE. A held key never repeats.
- Latency: the strobe appears in the cycle after ACCEPT, i.e. DEBOUNCE_CYCLES + 2 rising edges after the first sampled `tecla_activa` = 1.
- Key actions when `modo_monto` = 0 (PIN mode):
  - Digit: `digito` = code, `digito_stb` = 1 for one cycle. No digit-count limit; the controller counts.
  - ENTER/CLEAR: no effect.
  - Codes 0xC-0xF: no effect, no error.
- Key actions when `modo_monto` = 1 (amount mode):
  - Digit with ndig < MAX_DIGITS: monto = monto*10 + code (computed in 36 bits, truncation-free since MAX_DIGITS ≤ 9), ndig++.
  - Digit with ndig = MAX_DIGITS: ignored, `error_tecla` pulse, monto unchanged.
  - ENTER with ndig ≥ 1: `monto_stb` = 1 for one cycle with current monto. The next cycle clears monto and ndig to 0.
  - ENTER with ndig = 0: `error_tecla` pulse, no `monto_stb`.
  - CLEAR: monto = 0, ndig = 0, no strobe.
- Toggling `modo_monto` between keys does not clear the accumulator; only CLEAR, ENTER, or reset do.
- Strobes are mutually exclusive; at most one of `digito_stb`/`monto_stb`/`error_tecla` is high per cycle.
- `monto` holds its value between keys and after a rejected key.
- Reset mid-debounce or mid-strobe: immediate return to reset values; no partial strobe completes after reset deasserts.

Test Plan:
- PIN entry: DEBOUNCE_CYCLES = 4, modo_monto = 0; press keys 1, 2, 3, 4, each held 10 cycles with 5 released cycles between → four `digito_stb` pulses with `digito` = 1, 2, 3, 4, each exactly one cycle wide, 6 edges after press start.
- Bounce rejection: `tecla_activa` toggles 1,0,1,1,0 with code 7, then held for 6 cycles → exactly one `digito_stb` with `digito` = 7. Code changing 7→8 mid-debounce restarts the count and yields one strobe with `digito` = 8.
- Amount entry: modo_monto = 1; keys 2, 5, 0, ENTER → `monto_stb` once with `monto` = 250; `monto` = 0 the following cycle. Held key (40 cycles) produces no repeat.
- Overflow and limits: modo_monto = 1; enter nine 9s → `monto` = 999999999. Tenth digit → `error_tecla` pulse, monto unchanged. ENTER → `monto_stb` with 999999999. ENTER with no digits → `error_tecla` only.
- CLEAR and reset: keys 4, 2, CLEAR, 7, ENTER → `monto` = 7 at `monto_stb`. Assert reset during DEBOUNCE → all outputs 0 immediately and no strobe after release.
